// File: rtl/eca_rule_sequencer.sv
// Time-shared elementary cellular automaton engine: one rule lookup sequenced over a ring, one cell per clock.
// Latency: done pulses 1+G*(N_CELLS+1) cycles after an accepted start (PAUSE cycles excluded).
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise (no queuing).
// Optional: define ECA_SINGLE_STEP_EN to add a step input and a PAUSE state after each non-final commit.
module eca_rule_sequencer #(
    parameter int          N_CELLS      = 16,
    parameter int          GEN_W        = 8,
    parameter logic [7:0]  DEFAULT_RULE = 8'h45
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rule,
    input  logic [N_CELLS-1:0] seed,
    input  logic [GEN_W-1:0]   num_gens,
`ifdef ECA_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               busy,
    output logic               done,
    output logic [N_CELLS-1:0] state_out,
    output logic [GEN_W-1:0]   gen_count
);

    localparam int IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_COMMIT = 3'd2,
        S_DONE   = 3'd3,
        S_PAUSE  = 3'd4
    } fsm_t;

    fsm_t               state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [N_CELLS-1:0] next_buf;
    logic [7:0]         rule_q;
    logic [GEN_W-1:0]   gens_q;

    logic [IDX_W-1:0]   left_idx, right_idx;
    logic [2:0]         lut_idx;
    logic               cell_next;
    logic               last_gen;

    // Neighbour selection on the ring and the single shared rule lookup (MSB answers 000).
    always_comb begin
        left_idx  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        right_idx = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
        lut_idx   = {state_out[left_idx], state_out[idx], state_out[right_idx]};
        cell_next = rule_q[3'd7 - lut_idx];
        last_gen  = ((gen_count + GEN_W'(1)) == gens_q);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the busy/done status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (num_gens == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                busy = 1'b1;
`ifdef ECA_SINGLE_STEP_EN
                state_nxt = last_gen ? S_DONE : S_PAUSE;
`else
                state_nxt = last_gen ? S_DONE : S_RUN;
`endif
            end
`ifdef ECA_SINGLE_STEP_EN
            S_PAUSE: begin
                busy = 1'b1;
                if (step) state_nxt = S_RUN;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the job on accept, fill the shadow buffer in RUN, publish it in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            next_buf  <= '0;
            rule_q    <= DEFAULT_RULE;
            gens_q    <= '0;
            state_out <= '0;
            gen_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rule_q    <= rule;
                        gens_q    <= num_gens;
                        state_out <= seed;
                        gen_count <= '0;
                        idx       <= '0;
                    end
                end
                S_RUN: begin
                    next_buf[idx] <= cell_next;
                    idx           <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end
                S_COMMIT: begin
                    state_out <= next_buf;
                    gen_count <= gen_count + GEN_W'(1);
                    idx       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eca_rule_sequencer.sv
// Bench for eca_rule_sequencer: directed plan cases plus randomized runs against a ring model.
// Latency: measured in clock edges from the start-sampling edge to done.
// Backpressure: exercises start-while-busy rejection and mid-run reset abort.
module tb_eca_rule_sequencer;

    localparam int N  = 16;
    localparam int GW = 8;
    localparam int LIMIT = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    rule;
    logic [N-1:0]  seed;
    logic [GW-1:0] num_gens;
    logic          busy, done;
    logic [N-1:0]  state_out;
    logic [GW-1:0] gen_count;
`ifdef ECA_SINGLE_STEP_EN
    logic          step;
`endif

    int errors = 0;
    int checks = 0;

    eca_rule_sequencer #(.N_CELLS(N), .GEN_W(GW), .DEFAULT_RULE(8'h45)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rule(rule),
        .seed(seed),
        .num_gens(num_gens),
`ifdef ECA_SINGLE_STEP_EN
        .step(step),
`endif
        .busy(busy),
        .done(done),
        .state_out(state_out),
        .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    // One generation of the automaton straight from the neighbourhood rule.
    function automatic logic [N-1:0] eca_gen(input logic [7:0] r, input logic [N-1:0] s);
        logic [N-1:0] o;
        int v;
        for (int i = 0; i < N; i++) begin
            v = 4 * int'(s[(i + 1) % N]) + 2 * int'(s[i]) + int'(s[(i + N - 1) % N]);
            o[i] = r[7 - v];
        end
        return o;
    endfunction

    function automatic logic [N-1:0] eca_run(input logic [7:0] r, input logic [N-1:0] s, input int g);
        logic [N-1:0] x = s;
        for (int k = 0; k < g; k++) x = eca_gen(r, x);
        return x;
    endfunction

    function automatic int exp_latency(input int g);
`ifdef ECA_SINGLE_STEP_EN
        return 1 + g * (N + 1) + ((g > 0) ? g - 1 : 0);
`else
        return 1 + g * (N + 1);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one run, scramble the inputs after acceptance, and measure latency to done.
    task automatic run_job(input logic [7:0] r, input logic [N-1:0] s, input logic [GW-1:0] g,
                           output int lat);
        rule = r; seed = s; num_gens = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rule = 8'($urandom); seed = N'($urandom); num_gens = GW'($urandom);
        lat = 1;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    logic [7:0]   d_rule [6] = '{8'h45, 8'h45, 8'h80, 8'h01, 8'h00, 8'h45};
    logic [N-1:0] d_seed [6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hA5A5};
    logic [GW-1:0] d_gen [6] = '{8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd0};
    logic [N-1:0] d_exp  [6] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hA5A5};

    initial begin
        int lat, cnt, w;
        logic [7:0] rr;
        logic [N-1:0] ss;
        logic [GW-1:0] gg;

        rst_n = 1'b0; start = 1'b0; rule = 8'h00; seed = '0; num_gens = '0;
`ifdef ECA_SINGLE_STEP_EN
        step = 1'b1;
`endif
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_state", 32'(state_out), 32'd0);
        check("reset_gen", 32'(gen_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the plan, with literal expectations.
        for (int t = 0; t < 6; t++) begin
            run_job(d_rule[t], d_seed[t], d_gen[t], lat);
            check($sformatf("dir%0d_lat", t), 32'(lat), 32'(exp_latency(int'(d_gen[t]))));
            check($sformatf("dir%0d_state", t), 32'(state_out), 32'(d_exp[t]));
            check($sformatf("dir%0d_gen", t), 32'(gen_count), 32'(d_gen[t]));
            check($sformatf("dir%0d_busy_at_done", t), 32'(busy), 32'd0);
            @(posedge clk); #1;
            check($sformatf("dir%0d_hold", t), 32'({busy, done, state_out}), 32'({2'b00, d_exp[t]}));
        end

        // Randomized runs against the model.
        for (int t = 0; t < 8; t++) begin
            rr = 8'($urandom); ss = N'($urandom); gg = GW'($urandom_range(0, 4));
            run_job(rr, ss, gg, lat);
            check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(exp_latency(int'(gg))));
            check($sformatf("rnd%0d_state", t), 32'(state_out), 32'(eca_run(rr, ss, int'(gg))));
            check($sformatf("rnd%0d_gen", t), 32'(gen_count), 32'(gg));
            @(posedge clk); #1;
        end

        // Start pulsed while busy is dropped: one done, result from the first job only.
        rule = 8'h45; seed = 16'h0001; num_gens = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1; seed = 16'hFFFF; num_gens = 8'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        count_done(90, cnt);
        check("busy_start_one_done", 32'(cnt), 32'd1);
        check("busy_start_state", 32'(state_out), 32'(eca_run(8'h45, 16'h0001, 3)));
        check("busy_start_gen", 32'(gen_count), 32'd3);

        // Reset in the middle of generation 2 of 4.
        rule = 8'h45; seed = 16'h00F0; num_gens = 8'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (N + 1 + 5) @(posedge clk);
        #1;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        check("abort_state", 32'(state_out), 32'd0);
        check("abort_gen", 32'(gen_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        count_done(80, cnt);
        check("abort_no_done", 32'(cnt), 32'd0);
        run_job(8'h45, 16'h0001, 8'd1, lat);
        check("post_abort_lat", 32'(lat), 32'(exp_latency(1)));
        check("post_abort_state", 32'(state_out), 32'h0002);
        @(posedge clk); #1;

`ifdef ECA_SINGLE_STEP_EN
        // Single stepping: the engine parks after each non-final commit.
        step = 1'b0;
        rule = 8'h45; seed = 16'h0001; num_gens = 8'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int g = 1; g <= 2; g++) begin
            w = 0;
            while (gen_count != GW'(g) && w < LIMIT) begin @(posedge clk); #1; w++; end
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("pause%0d_state", g), 32'(state_out), 32'(16'h0001 << g));
            check($sformatf("pause%0d_busy", g), 32'({busy, done}), 32'b10);
            step = 1'b1; @(posedge clk); #1; step = 1'b0;
        end
        w = 0;
        while (!done && w < LIMIT) begin @(posedge clk); #1; w++; end
        check("pause_done_seen", 32'(done), 32'd1);
        check("pause_final_state", 32'(state_out), 32'h0008);
        step = 1'b1;
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eca_rule_sequencer.md
Name: eca_rule_sequencer

Overview:
- Time-shared controller that evolves a 1-D elementary cellular automaton ring of N_CELLS cells for a programmable number of generations.
- Owns a single 3-input rule lookup, the same truth-table function as the wolfram 0xNN gate modules, with {in1,in2,in3} = {left,center,right}.
- Sequences that lookup across all cells, one cell per clock, with double-buffered state.
- Sits between a host/test harness (start/done handshake) and downstream logic consuming the evolved state vector.

Parameters:
- N_CELLS, 16, ring length (>=3)
- GEN_W, 8, width of generation count
- DEFAULT_RULE, 8'h45, rule loaded at reset into the internal rule register

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request run; sampled only in IDLE
- rule  input  8  Wolfram rule code; latched on accepted start
- seed  input  N_CELLS  initial generation; latched on accepted start
- num_gens  input  GEN_W  generations to compute; latched on accepted start
- busy  output  1  high in RUN/COMMIT
- done  output  1  one-cycle pulse when the run completes
- state_out  output  N_CELLS  current committed generation
- gen_count  output  GEN_W  generations committed so far in this run

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; busy=0, done=0, state_out=0, gen_count=0.
  - Cell index=0; next-buffer=0; rule register=DEFAULT_RULE.
  - Reset mid-run aborts immediately with no done pulse.
- Rule indexing (Cello convention): idx={left,center,right}; next cell = rule[7-idx]. So rule MSB is the output for 000 and the LSB is the output for 111.
- Neighbours of cell i:
  - left = bit (i+1) mod N_CELLS; center = bit i; right = bit (i-1) mod N_CELLS.
  - Wrap-around: cell N-1 takes its left from bit 0; cell 0 takes its right from bit N-1.
- States:
  - IDLE: on start=1, latch rule/seed/num_gens; state_out<=seed; gen_count<=0; cell index<=0. Go to DONE if num_gens==0, else RUN.
  - RUN: each cycle writes next-buffer[idx] from the committed state_out. state_out is not modified during RUN. idx increments; at idx==N_CELLS-1 go to COMMIT.
  - COMMIT (1 cycle): state_out<=next-buffer; gen_count<=gen_count+1; idx<=0. If gen_count+1==num_gens go to DONE, else RUN.
  - DONE (1 cycle): done=1, busy=0; then IDLE.
- Latency:
  - done is high exactly 1+G*(N_CELLS+1) cycles after the cycle in which start was sampled (G = num_gens).
  - G=0 gives 1 cycle; G=1, N=16 gives 18 cycles.
- start while busy or in DONE is ignored; there is no queuing. Input changes after acceptance have no effect.
- state_out and gen_count hold their final values in IDLE until the next accepted start.
- gen_count never wraps within a run (num_gens <= 2^GEN_W-1).

Optional Feature:
- Macro: ECA_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - After each COMMIT that does not finish the run, FSM enters PAUSE: busy=1, state_out stable.
  - PAUSE waits for step=1, then returns to RUN with idx=0. The latency formula then excludes pause cycles.
  - start is ignored in PAUSE; reset exits PAUSE.
- When undefined: no step port; COMMIT goes directly to RUN; latency as above.

Test Plan:
- rule=8'h45, seed=16'h0001, num_gens=1 -> done 18 cycles after start, state_out=16'h0002, gen_count=1, busy low after done.
- rule=8'h45, seed=16'hFFFF, num_gens=5 -> state_out stays 16'hFFFF each commit; done at cycle 86; gen_count=5.
- rule=8'h80, seed=16'h0000, num_gens=1 -> state_out=16'hFFFF (checks MSB = index 000). rule=8'h01, seed=16'hFFFF -> 16'hFFFF; rule=8'h00 -> 16'h0000.
- num_gens=0, seed=16'hA5A5 -> done 1 cycle after start, state_out=16'hA5A5, gen_count=0. A second start pulsed while busy during a 3-generation run -> ignored, exactly one done.
- Assert rst_n=0 mid-RUN (gen 2 of 4) -> outputs immediately 0, no done pulse. A new start after release runs cleanly from seed.
- ECA_SINGLE_STEP_EN, rule=8'h45, seed=16'h0001, num_gens=3 -> PAUSE with state_out=16'h0002, then 16'h0004 after step. done only after the third generation with state_out=16'h0008.
